serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell built from two half-subtractor stages plus an OR on the borrows, with a registered borrow between cycles. It consumes the D/B outputs of that cell each cycle and packs them into a parallel result with a start/done handshake. The block sits downstream of the half-subtractor datapath, for area-constrained paths where WIDTH-wide parallel subtraction is not wanted.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request. Sampled only in IDLE.
- `a`, input, WIDTH: minuend, sampled on the edge that accepts `start`.
- `b`, input, WIDTH: subtrahend, sampled on the edge that accepts `start`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse, high while in DONE.
- `diff`, output, WIDTH: (a − b) mod 2^WIDTH. Valid from `done` until the next accepted `start`.
- `borrow_out`, output, 1: 1 iff a < b (unsigned). Same validity as `diff`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → load shift registers A←a, B←b; clear borrow register br←0 and bit counter cnt←0; go to RUN.
  - `start`=0 → stay in IDLE.
  - `diff` and `borrow_out` hold their previous values.
- RUN, each edge:
  - d = A[0] ^ B[0] ^ br.
  - bo = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br).
  - Shift the result register right with d entering at the MSB.
  - Shift A and B right by one.
  - br←bo; cnt←cnt+1.
- On the RUN edge where cnt == WIDTH−1:
  - Final bit written; `diff` now holds the full result.
  - `borrow_out`←bo of that bit.
  - Go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` is ignored in RUN and DONE; no queuing, no error flag.
- `a`/`b` changes after acceptance have no effect.
- Counter width is $clog2(WIDTH), with a minimum of 1. cnt never wraps; it is reloaded on acceptance.
- The result register is updated only during RUN. Intermediate `diff` values during RUN are not valid and must not be sampled.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
  - A, B, br, cnt are cleared.
  - Reset overrides `start` on the same edge.
- Reset mid-RUN or in DONE abandons the operation. No `done` pulse follows. Outputs take their reset values on that edge.
- If `start` is accepted at edge E0:
  - `busy` is high in the cycles after edges E0 … E0+WIDTH−1.
  - `done` is high in the cycle after edge E0+WIDTH, and `busy` is 0 there.
  - Latency: WIDTH+1 edges from the accepting edge to `done` visible.
- Earliest next acceptance is edge E0+WIDTH+2. Maximum throughput: one operation per WIDTH+2 cycles.
- `start` held continuously high is accepted at every IDLE occurrence, giving back-to-back operations at that rate.
- `busy` and `done` are never high together. Both are registered outputs (no combinational path from inputs).

## Test plan
- WIDTH=8, a=0x5A, b=0x23, pulse `start` → `done` exactly 9 edges after acceptance, `diff`=0x37, `borrow_out`=0; `busy` high for 8 cycles.
- a=0x00, b=0x01 → `diff`=0xFF, `borrow_out`=1. Also a=0x80, b=0x80 → `diff`=0x00, `borrow_out`=0.
- Accept a=0x10, b=0x01. Two cycles later assert `start` with a=0xFF, b=0xFF and change `a`/`b`. → result still `diff`=0x0F, `borrow_out`=0; only one `done` pulse.
- Drop `rst_n` at the 4th RUN cycle → next cycle `busy`=0, `diff`=0, `borrow_out`=0, no `done`. Then a=3, b=5 → `diff`=0xFE, `borrow_out`=1.
- `start` held high with a=7, b=2 → `done` pulses every 10 cycles, each with `diff`=0x05, `borrow_out`=0.
- WIDTH=4, exhaustive 256 pairs → `diff` == (a−b)&0xF and `borrow_out` == (a<b) for every pair, checked against a reference model on each `done`.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Latency: WIDTH+1 edges from the edge accepting start to done visible; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored (not queued) while busy or done.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   rst_n      - synchronous active-low reset, overrides start
//   start      - request, accepted only in IDLE together with a/b
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   busy       - high while the serial datapath is running
//   done       - one-cycle pulse when diff/borrow_out become valid
//   diff       - (a - b) mod 2^WIDTH, held until the next accepted start
//   borrow_out - 1 iff a < b (unsigned), same validity as diff

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Bit counter only needs to reach WIDTH-1; it is held (not incremented)
  // on the final bit so it never wraps when WIDTH is a power of two.
  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  // Half subtractor: returns {borrow, difference} of x - y.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

  // Full-subtractor cell: two half-subtractor stages, borrows ORed.
  // Stage 0 subtracts the operand bits, stage 1 subtracts the stored borrow.
  logic [1:0]       hs0;
  logic [1:0]       hs1;
  logic             diff_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    hs0      = half_sub(a_q[0], b_q[0]);
    hs1      = half_sub(hs0[0], br_q);
    diff_bit = hs1[0];
    br_d     = hs0[1] | hs1[1];
    // Result fills from the MSB end; after WIDTH shifts bit 0 holds the LSB.
    res_d    = {diff_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          if (cnt_q == LAST_BIT) begin
            // Final bit: the borrow out of the MSB is the unsigned a<b flag.
            borrow_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = res_q;
  assign borrow_out = borrow_q;

  // busy and done are mutually exclusive and done never lasts two cycles.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
  a_done_pulse:     assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       bo;
  } exp8_t;

  typedef struct {
    logic [3:0] d;
    logic       bo;
  } exp4_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  exp8_t sb8[$];
  exp4_t sb4[$];
  vec_t  tbl[8];

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every done pops one expectation.
  always @(negedge clk) begin
    exp8_t e;
    if (done8 === 1'b1) begin
      chk("busy_with_done8", {31'd0, busy8}, 32'd0);
      if (sb8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        chk("diff8", {24'd0, diff8}, {24'd0, e.d});
        chk("borrow8", {31'd0, bo8}, {31'd0, e.bo});
      end
    end
  end

  always @(negedge clk) begin
    exp4_t e;
    if (done4 === 1'b1) begin
      chk("busy_with_done4", {31'd0, busy4}, 32'd0);
      if (sb4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = sb4.pop_front();
        chk("diff4", {28'd0, diff4}, {28'd0, e.d});
        chk("borrow4", {31'd0, bo4}, {31'd0, e.bo});
      end
    end
  end

  // Waits (bounded) for done; k counts negedges from the call, nb counts busy cycles.
  task automatic wait_done(input bit w4, output int k, output int nb);
    bit seen;
    k = 0;
    nb = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if ((w4 ? busy4 : busy8) === 1'b1) nb++;
      if ((w4 ? done4 : done8) === 1'b1) seen = 1;
    end
    if (!seen) begin
      chk(w4 ? "timeout_done4" : "timeout_done8", 32'd0, 32'd1);
    end
  endtask

  // Called just after a posedge with the DUT in IDLE; returns just after a posedge in IDLE.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic [7:0] ed, input logic eb, output int k, output int nb);
    start8 = 1'b1;
    a8 = ai;
    b8 = bi;
    @(posedge clk);
    sb8.push_back('{ed, eb});
    #1 start8 = 1'b0;
    wait_done(1'b0, k, nb);
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [3:0] ai, input logic [3:0] bi);
    int k, nb;
    logic [3:0] dm;
    start4 = 1'b1;
    a4 = ai;
    b4 = bi;
    @(posedge clk);
    dm = ai - bi;
    sb4.push_back('{dm, (ai < bi)});
    #1 start4 = 1'b0;
    wait_done(1'b1, k, nb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, nb, dones;
    tbl[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[4] = '{8'h01, 8'hFF, 8'h02, 1'b1};
    tbl[5] = '{8'h3C, 8'h3D, 8'hFF, 1'b1};
    tbl[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_diff8", {24'd0, diff8}, 32'd0);
    chk("rst_borrow8", {31'd0, bo8}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_diff4", {28'd0, diff4}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, each with latency and busy-length checks.
    for (int i = 0; i < 8; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, k, nb);
      chk($sformatf("latency8[%0d]", i), k, 32'd9);
      chk($sformatf("busy_cycles8[%0d]", i), nb, 32'd8);
    end

    // start during RUN and a/b changes after acceptance are ignored.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk);
    sb8.push_back('{8'h0F, 1'b0});
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (3) @(posedge clk);
    #1 start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA;
    wait_done(1'b0, k, nb);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset in the 4th RUN cycle abandons the operation.
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy8", {31'd0, busy8}, 32'd0);
    chk("midrst_done8", {31'd0, done8}, 32'd0);
    chk("midrst_diff8", {24'd0, diff8}, 32'd0);
    chk("midrst_borrow8", {31'd0, bo8}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    chk("no_done_after_rst", dones, 32'd0);
    @(posedge clk);
    #1;
    op8(8'd3, 8'd5, 8'hFE, 1'b1, k, nb);
    chk("latency8_after_rst", k, 32'd9);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    for (int n = 0; n < 3; n++) sb8.push_back('{8'h05, 1'b0});
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd2;
    for (int n = 0; n < 3; n++) begin
      wait_done(1'b0, k, nb);
      if (n > 0) chk($sformatf("b2b_interval[%0d]", n), k, 32'd10);
      if (n == 2) start8 = 1'b0;
    end
    @(posedge clk);
    #1;

    // WIDTH=4 exhaustive against the model.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j));
      end
    end

    repeat (4) @(posedge clk);
    chk("sb8_drained", sb8.size(), 32'd0);
    chk("sb4_drained", sb4.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
